// File: rtl/game_pkg.sv
// game_pkg: shared cheese controller state encoding and default tuning values.
package game_pkg;
   typedef enum logic [2:0] {IDLE, GEN, SETTLE, CHECK, VISIBLE, RESPAWN, DONE} cheese_state_t;
   localparam int CHEESE_RESPAWN_FRAMES = 60;
   localparam int CHEESE_WIN_SCORE = 10;
   localparam int CHEESE_MAX_RETRY = 3;
   localparam int CHEESE_TIMEOUT_FRAMES = 600;
   function automatic int max_i(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/cheese_spawn_ctrl_if.sv
// cheese_spawn_ctrl_if: request strobe and returned position of the random platform generator.
interface cheese_spawn_ctrl_if #(parameter int POS_W = 12);
   logic rnd_generate;
   logic [POS_W-1:0] rnd_x;
   logic [POS_W-1:0] rnd_y;
   modport master(output rnd_generate, input rnd_x, input rnd_y);
   modport slave(input rnd_generate, output rnd_x, output rnd_y);
endinterface

// File: rtl/cheese_spawn_ctrl_frame_timer.sv
// frame_timer: loadable frame_tick counter; done fires on the tick that reaches last.
module frame_timer #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             tick,
   input  logic [CNT_W-1:0] last,
   output logic             done
);
   logic [CNT_W-1:0] cnt;
   assign done = tick && cnt == last;
   always_ff @(posedge clk) begin
      if (rst || load) cnt <= '0;
      else if (tick) cnt <= cnt + CNT_W'(1);
   end
endmodule

// File: rtl/cheese_spawn_ctrl.sv
// cheese_spawn_ctrl: cheese spawn, collection, respawn delay, score and win sequencing.
// Defining CHEESE_TIMEOUT_EN relocates cheese left uncollected for TIMEOUT_FRAMES frames.
module cheese_spawn_ctrl
   import game_pkg::*;
#(
   parameter int RESPAWN_FRAMES = CHEESE_RESPAWN_FRAMES,
   parameter int MAX_RETRY      = CHEESE_MAX_RETRY,
   parameter int WIN_SCORE      = CHEESE_WIN_SCORE,
   parameter int SCORE_W        = 8,
   parameter int POS_W          = 12,
   parameter int TIMEOUT_FRAMES = CHEESE_TIMEOUT_FRAMES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               game_en,
   input  logic               frame_tick,
   input  logic               collect,
   cheese_spawn_ctrl_if.master gen,
   output logic [POS_W-1:0]   cheese_x,
   output logic [POS_W-1:0]   cheese_y,
   output logic               cheese_visible,
   output logic [SCORE_W-1:0] score,
   output logic               win
);
   localparam int CNT_W = $clog2(max_i(RESPAWN_FRAMES, TIMEOUT_FRAMES));
   localparam int RW = $clog2(MAX_RETRY + 1);
   cheese_state_t state, state_n;
   logic [RW-1:0] retry, retry_n;
   logic have_prev, have_prev_n;
   logic [POS_W-1:0] last_y, last_y_n, x_n, y_n;
   logic vis_n, win_n, gen_q, gen_n, load, tick_en, done;
   logic [SCORE_W-1:0] score_n;
   logic [CNT_W-1:0] last;
   assign gen.rnd_generate = gen_q;
   assign last = state == RESPAWN ? CNT_W'(RESPAWN_FRAMES - 1) : CNT_W'(TIMEOUT_FRAMES - 1);
`ifdef CHEESE_TIMEOUT_EN
   assign tick_en = frame_tick && (state == RESPAWN || state == VISIBLE);
`else
   assign tick_en = frame_tick && state == RESPAWN;
`endif
   frame_timer #(.CNT_W(CNT_W)) u_timer (
      .clk (clk),
      .rst (rst),
      .load(load),
      .tick(tick_en),
      .last(last),
      .done(done)
   );
   always_comb begin
      state_n = state;
      retry_n = retry;
      have_prev_n = have_prev;
      last_y_n = last_y;
      x_n = cheese_x;
      y_n = cheese_y;
      vis_n = cheese_visible;
      score_n = score;
      win_n = win;
      load = 1'b0;
      if (!game_en) begin
         state_n = IDLE;
         vis_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state_n = GEN;
               score_n = '0;
               win_n = 1'b0;
               have_prev_n = 1'b0;
               retry_n = '0;
            end
            GEN: state_n = SETTLE;
            SETTLE: state_n = CHECK;
            CHECK: begin
               if (have_prev && gen.rnd_y == last_y && retry < RW'(MAX_RETRY)) begin
                  retry_n = retry + RW'(1);
                  state_n = GEN;
               end else begin
                  x_n = gen.rnd_x;
                  y_n = gen.rnd_y;
                  last_y_n = gen.rnd_y;
                  have_prev_n = 1'b1;
                  retry_n = '0;
                  vis_n = 1'b1;
                  load = 1'b1;
                  state_n = VISIBLE;
               end
            end
            VISIBLE: begin
               if (collect) begin
                  vis_n = 1'b0;
                  score_n = score < SCORE_W'(WIN_SCORE) ? score + SCORE_W'(1) : score;
                  if (score_n == SCORE_W'(WIN_SCORE)) begin
                     win_n = 1'b1;
                     state_n = DONE;
                  end else begin
                     load = 1'b1;
                     state_n = RESPAWN;
                  end
               end
`ifdef CHEESE_TIMEOUT_EN
               else if (done) begin
                  vis_n = 1'b0;
                  state_n = GEN;
               end
`endif
            end
            RESPAWN: state_n = done ? GEN : RESPAWN;
            DONE: begin
               vis_n = 1'b0;
               win_n = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end
      gen_n = state_n == GEN;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         retry <= '0;
         have_prev <= 1'b0;
         last_y <= '0;
         cheese_x <= '0;
         cheese_y <= '0;
         cheese_visible <= 1'b0;
         score <= '0;
         win <= 1'b0;
         gen_q <= 1'b0;
      end else begin
         state <= state_n;
         retry <= retry_n;
         have_prev <= have_prev_n;
         last_y <= last_y_n;
         cheese_x <= x_n;
         cheese_y <= y_n;
         cheese_visible <= vis_n;
         score <= score_n;
         win <= win_n;
         gen_q <= gen_n;
      end
   end
endmodule

// File: tb/tb_cheese_spawn_ctrl.sv
// tb_cheese_spawn_ctrl: directed scenarios for cheese_spawn_ctrl with a queue-driven generator model.
module tb_cheese_spawn_ctrl;
   import game_pkg::*;
   logic clk = 1'b0;
   logic rst, game_en, frame_tick, collect;
   logic [11:0] cheese_x, cheese_y;
   logic cheese_visible, win;
   logic [7:0] score;
   int vec = 0;
   int errs = 0;
   int strobes = 0;
   logic [11:0] yq[$];
   cheese_spawn_ctrl_if #(.POS_W(12)) gif ();
   cheese_spawn_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .game_en       (game_en),
      .frame_tick    (frame_tick),
      .collect       (collect),
      .gen           (gif),
      .cheese_x      (cheese_x),
      .cheese_y      (cheese_y),
      .cheese_visible(cheese_visible),
      .score         (score),
      .win           (win)
   );
   always #5 clk = ~clk;
   // A strobe seen in GEN loads the next queued y; the value is stable by CHECK.
   task automatic step();
      @(posedge clk);
      #1;
      if (gif.rnd_generate === 1'b1) begin
         strobes++;
         if (yq.size() > 0) gif.rnd_y = yq.pop_front();
      end
   endtask
   task automatic pulse_tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask
   task automatic pulse_collect();
      collect = 1'b1;
      step();
      collect = 1'b0;
   endtask
   task automatic wait_visible(output int n);
      n = 0;
      while (cheese_visible !== 1'b1 && n < 40) begin
         step();
         n++;
      end
   endtask
   task automatic respawn(input string nm);
      int s0;
      s0 = strobes;
      repeat (59) begin
         pulse_tick();
         step();
      end
      vec++;
      if (strobes !== s0) begin errs++; $display("FAIL %s_early: strobes %0d want %0d", nm, strobes - s0, 0); end
      pulse_tick();
      vec++;
      if (gif.rnd_generate !== 1'b1) begin errs++; $display("FAIL %s_strobe: rnd_generate %b want 1", nm, gif.rnd_generate); end
   endtask
   task automatic test_reset();
      step();
      step();
      vec++;
      if (cheese_visible !== 1'b0) begin errs++; $display("FAIL rst_visible: got %b want 0", cheese_visible); end
      vec++;
      if (gif.rnd_generate !== 1'b0) begin errs++; $display("FAIL rst_gen: got %b want 0", gif.rnd_generate); end
      vec++;
      if (score !== 8'd0 || win !== 1'b0) begin errs++; $display("FAIL rst_score_win: got %0d/%b want 0/0", score, win); end
      vec++;
      if (cheese_x !== 12'd0 || cheese_y !== 12'd0) begin errs++; $display("FAIL rst_pos: got %0d,%0d want 0,0", cheese_x, cheese_y); end
      rst = 1'b0;
      step();
      vec++;
      if (dut.state !== IDLE) begin errs++; $display("FAIL idle_hold: state %0d want %0d", dut.state, IDLE); end
   endtask
   task automatic test_spawn();
      int s0;
      s0 = strobes;
      game_en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         vec++;
         if (gif.rnd_generate !== (i == 1)) begin errs++; $display("FAIL spawn_gen_c%0d: got %b want %b", i, gif.rnd_generate, i == 1); end
         vec++;
         if (cheese_visible !== (i == 4)) begin errs++; $display("FAIL spawn_vis_c%0d: got %b want %b", i, cheese_visible, i == 4); end
      end
      vec++;
      if (cheese_y !== 12'd300 || cheese_x !== 12'd100) begin errs++; $display("FAIL spawn_pos: got %0d,%0d want 100,300", cheese_x, cheese_y); end
      vec++;
      if (strobes - s0 !== 1) begin errs++; $display("FAIL spawn_strobes: got %0d want 1", strobes - s0); end
   endtask
   task automatic test_collect();
      pulse_collect();
      vec++;
      if (score !== 8'd1 || cheese_visible !== 1'b0) begin errs++; $display("FAIL collect: score %0d vis %b want 1 0", score, cheese_visible); end
      vec++;
      if (dut.state !== RESPAWN) begin errs++; $display("FAIL collect_state: got %0d want %0d", dut.state, RESPAWN); end
      pulse_collect();
      vec++;
      if (score !== 8'd1) begin errs++; $display("FAIL hidden_collect: score %0d want 1", score); end
   endtask
   task automatic test_retry();
      int s0, n;
      yq = '{12'd300, 12'd300, 12'd180};
      s0 = strobes;
      respawn("retry");
      wait_visible(n);
      vec++;
      if (n !== 9) begin errs++; $display("FAIL retry_latency: got %0d want 9", n); end
      vec++;
      if (strobes - s0 !== 3) begin errs++; $display("FAIL retry_strobes: got %0d want 3", strobes - s0); end
      vec++;
      if (cheese_y !== 12'd180) begin errs++; $display("FAIL retry_y: got %0d want 180", cheese_y); end
   endtask
   task automatic test_max_retry();
      int s0, n;
      pulse_collect();
      s0 = strobes;
      respawn("maxr");
      wait_visible(n);
      vec++;
      if (n !== 12) begin errs++; $display("FAIL maxr_latency: got %0d want 12", n); end
      vec++;
      if (strobes - s0 !== 4) begin errs++; $display("FAIL maxr_strobes: got %0d want 4", strobes - s0); end
      vec++;
      if (cheese_y !== 12'd180 || score !== 8'd2) begin errs++; $display("FAIL maxr_y_score: got %0d/%0d want 180/2", cheese_y, score); end
   endtask
   task automatic test_win();
      int n;
      for (int k = 3; k <= 10; k++) begin
         collect = 1'b1;
         frame_tick = (k == 5);
         step();
         collect = 1'b0;
         frame_tick = 1'b0;
         vec++;
         if (score !== 8'(k)) begin errs++; $display("FAIL win_score_%0d: got %0d want %0d", k, score, k); end
         if (k < 10) begin
            yq.push_back(12'(k * 10));
            respawn($sformatf("resp%0d", k));
            wait_visible(n);
            vec++;
            if (n !== 3 || cheese_y !== 12'(k * 10)) begin errs++; $display("FAIL win_spawn_%0d: lat %0d y %0d want 3 %0d", k, n, cheese_y, k * 10); end
         end
      end
      vec++;
      if (win !== 1'b1 || cheese_visible !== 1'b0 || dut.state !== DONE) begin errs++; $display("FAIL win_done: win %b vis %b state %0d want 1 0 %0d", win, cheese_visible, dut.state, DONE); end
      pulse_collect();
      vec++;
      if (score !== 8'd10 || dut.state !== DONE) begin errs++; $display("FAIL done_hold: score %0d state %0d want 10 %0d", score, dut.state, DONE); end
      game_en = 1'b0;
      step();
      vec++;
      if (dut.state !== IDLE || win !== 1'b1 || score !== 8'd10) begin errs++; $display("FAIL stop: state %0d win %b score %0d want %0d 1 10", dut.state, win, score, IDLE); end
      game_en = 1'b1;
      step();
      vec++;
      if (score !== 8'd0 || win !== 1'b0 || gif.rnd_generate !== 1'b1) begin errs++; $display("FAIL restart: score %0d win %b gen %b want 0 0 1", score, win, gif.rnd_generate); end
   endtask
   task automatic test_rst_mid();
      step();
      vec++;
      if (dut.state !== SETTLE) begin errs++; $display("FAIL mid_settle: state %0d want %0d", dut.state, SETTLE); end
      gif.rnd_y = 12'd999;
      rst = 1'b1;
      step();
      vec++;
      if (dut.state !== IDLE || cheese_visible !== 1'b0 || cheese_y !== 12'd0 || gif.rnd_generate !== 1'b0) begin errs++; $display("FAIL mid_rst: state %0d vis %b y %0d gen %b want %0d 0 0 0", dut.state, cheese_visible, cheese_y, gif.rnd_generate, IDLE); end
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) step();
      vec++;
      if (cheese_visible !== 1'b1 || cheese_y !== 12'd999) begin errs++; $display("FAIL mid_respawn: vis %b y %0d want 1 999", cheese_visible, cheese_y); end
   endtask
`ifdef CHEESE_TIMEOUT_EN
   task automatic test_timeout();
      int s0, n;
      s0 = strobes;
      yq.push_back(12'd555);
      repeat (599) begin
         pulse_tick();
         step();
      end
      vec++;
      if (strobes !== s0) begin errs++; $display("FAIL to_early: strobes %0d want 0", strobes - s0); end
      pulse_tick();
      vec++;
      if (gif.rnd_generate !== 1'b1 || cheese_visible !== 1'b0 || score !== 8'd0) begin errs++; $display("FAIL to_reloc: gen %b vis %b score %0d want 1 0 0", gif.rnd_generate, cheese_visible, score); end
      wait_visible(n);
      vec++;
      if (n !== 3 || cheese_y !== 12'd555) begin errs++; $display("FAIL to_spawn: lat %0d y %0d want 3 555", n, cheese_y); end
      repeat (599) begin
         pulse_tick();
         step();
      end
      collect = 1'b1;
      frame_tick = 1'b1;
      step();
      collect = 1'b0;
      frame_tick = 1'b0;
      vec++;
      if (score !== 8'd1 || gif.rnd_generate !== 1'b0 || dut.state !== RESPAWN) begin errs++; $display("FAIL to_collect: score %0d gen %b state %0d want 1 0 %0d", score, gif.rnd_generate, dut.state, RESPAWN); end
   endtask
`endif
   initial begin
      rst = 1'b1;
      game_en = 1'b0;
      frame_tick = 1'b0;
      collect = 1'b0;
      gif.rnd_x = 12'd100;
      gif.rnd_y = 12'd300;
      test_reset();
      test_spawn();
      test_collect();
      test_retry();
      test_max_retry();
      test_win();
      test_rst_mid();
`ifdef CHEESE_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
